// File: rtl/cdc_pkg.sv
// Shared definitions for the source and destination halves of the toggle
// request/acknowledge clock-domain crossing.
package cdc_pkg;

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_WAIT_ACK = 1'b1
  } tx_state_e;

  // A toggle handshake has a word in flight whenever the two levels differ.
  function automatic logic req_pending(input logic req, input logic ack);
    return req ^ ack;
  endfunction

endpackage

// File: rtl/two_stage_sync.sv
// Two-flop level synchronizer bringing an asynchronous signal into clk.
module two_stage_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q2
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_q2;

  // Metastability-settling chain; only r_q2 is used by downstream logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_q2   <= '0;
    end else begin
      r_meta <= din;
      r_q2   <= r_meta;
    end
  end

  assign q2 = r_q2;

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source half of a two-phase toggle CDC: holds one word stable on tx_data,
// toggles tx_req, and waits for the resynchronized acknowledge toggle.
module cdc_handshake_tx
  import cdc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_req,
  input  logic             ack_async,
  output logic             done,
  output logic             err
);

  tx_state_e        r_state;
  tx_state_e        w_state_nxt;
  logic [WIDTH-1:0] r_tx_data;
  logic             r_tx_req;
  logic             r_done;
  logic             r_err;
  logic             w_ack_s;
  logic             w_pending;
  logic             w_accept;

  two_stage_sync #(
    .WIDTH (1)
  ) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ack_async),
    .q2    (w_ack_s)
  );

  assign w_pending = req_pending(r_tx_req, w_ack_s);
  assign w_accept  = (r_state == S_IDLE) && valid;

  // Next-state selection; ready depends on state only, never on valid.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (valid) begin
          w_state_nxt = S_WAIT_ACK;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_ACK: begin
        if (!w_pending) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT_ACK;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, request toggle, held data word, completion pulse and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_tx_data <= '0;
      r_tx_req  <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == S_WAIT_ACK) && !w_pending;
      if (w_accept) begin
        r_tx_data <= data;
        r_tx_req  <= ~r_tx_req;
      end
      // An ack toggle while idle means the destination acknowledged nothing.
      if ((r_state == S_IDLE) && w_pending) begin
        r_err <= 1'b1;
      end
    end
  end

  assign ready   = (r_state == S_IDLE);
  assign tx_data = r_tx_data;
  assign tx_req  = r_tx_req;
  assign done    = r_done;
  assign err     = r_err;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed self-checking bench for cdc_handshake_tx with a simple destination model.
module tb_cdc_handshake_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [3:0] data = 4'h0;
  logic       ready;
  logic [3:0] tx_data;
  logic       tx_req;
  logic       ack_async = 1'b0;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  logic       dest_en = 1'b0;
  logic       dest_req_seen = 1'b0;
  int         dest_cnt = 0;
  logic [3:0] cap [0:2];
  int         cap_n = 0;
  logic       mon_en = 1'b0;
  int         done_cnt = 0;

  cdc_handshake_tx #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (valid),
    .data      (data),
    .ready     (ready),
    .tx_data   (tx_data),
    .tx_req    (tx_req),
    .ack_async (ack_async),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ack_async = 1'b0;
    valid = 1'b0;
    #1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Destination: capture and acknowledge four cycles after seeing a new request.
  always begin
    @(posedge clk);
    #2;
    if (dest_en && (tx_req != dest_req_seen)) begin
      if (dest_cnt == 3) begin
        if (cap_n < 3) cap[cap_n] = tx_data;
        cap_n++;
        dest_req_seen = tx_req;
        ack_async = tx_req;
        dest_cnt = 0;
      end else begin
        dest_cnt++;
      end
    end
  end

  always begin
    @(posedge clk);
    #3;
    if (mon_en && done) done_cnt++;
  end

  logic [3:0] words [0:2];
  logic       req_seq [0:2];
  int         guard;
  logic       err_seen;
  logic       done_seen;

  initial begin
    words[0] = 4'h3; words[1] = 4'h5; words[2] = 4'hC;

    // Reset state
    rst_n = 1'b0;
    #1;
    tick();
    tick();
    check("rst_ready", ready, 1);
    check("rst_tx_req", tx_req, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    tick();

    // Single transfer with stability checks while waiting
    data = 4'hA; valid = 1'b1;
    tick();
    valid = 1'b0;
    check("single_tx_data", tx_data, 4'hA);
    check("single_tx_req", tx_req, 1);
    check("single_ready", ready, 0);
    for (int i = 0; i < 3; i++) begin
      data = 4'(i + 1); valid = 1'b1;
      tick();
      check("stable_tx_data", tx_data, 4'hA);
      check("stable_tx_req", tx_req, 1);
      check("stable_done", done, 0);
    end
    valid = 1'b0;
    ack_async = 1'b1;
    tick();
    check("ack_e1_done", done, 0);
    tick();
    check("ack_e2_done", done, 0);
    tick();
    check("ack_e3_done", done, 1);
    check("ack_e3_ready", ready, 1);
    tick();
    check("ack_e4_done", done, 0);
    check("single_no_err", err, 0);
    check("single_keep_data", tx_data, 4'hA);

    // Back-to-back through the destination model
    do_reset();
    dest_req_seen = 1'b0; dest_cnt = 0; cap_n = 0; done_cnt = 0;
    dest_en = 1'b1; mon_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      data = words[k]; valid = 1'b1;
      guard = 0;
      while (!ready && guard < 50) begin
        tick();
        guard++;
      end
      check("b2b_ready_wait", guard < 50, 1);
      tick();
      req_seq[k] = tx_req;
    end
    valid = 1'b0;
    guard = 0;
    while (!(ready && cap_n >= 3 && !done) && guard < 50) begin
      tick();
      guard++;
    end
    tick();
    check("b2b_finish", guard < 50, 1);
    check("b2b_req0", req_seq[0], 1);
    check("b2b_req1", req_seq[1], 0);
    check("b2b_req2", req_seq[2], 1);
    check("b2b_done_cnt", done_cnt, 3);
    check("b2b_cap_n", cap_n, 3);
    check("b2b_cap0", cap[0], 4'h3);
    check("b2b_cap1", cap[1], 4'h5);
    check("b2b_cap2", cap[2], 4'hC);
    check("b2b_no_err", err, 0);
    dest_en = 1'b0; mon_en = 1'b0;

    // Stray acknowledge while idle
    do_reset();
    ack_async = 1'b1;
    err_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (err) err_seen = 1'b1;
    end
    check("stray_err", err_seen, 1);
    tick();
    tick();
    check("stray_err_sticky", err, 1);
    data = 4'h9; valid = 1'b1;
    tick();
    valid = 1'b0;
    check("stray_accept_req", tx_req, 1);
    check("stray_accept_data", tx_data, 4'h9);
    check("stray_accept_ready", ready, 0);
    tick();
    check("stray_done", done, 1);
    check("stray_err_hold", err, 1);

    // Reset in the middle of a transfer
    do_reset();
    data = 4'h6; valid = 1'b1;
    tick();
    valid = 1'b0;
    check("mid_wait_ready", ready, 0);
    check("mid_wait_req", tx_req, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", tx_req, 0);
    check("mid_rst_ready", ready, 1);
    check("mid_rst_data", tx_data, 0);
    check("mid_rst_err", err, 0);
    tick();
    rst_n = 1'b1;
    tick();
    data = 4'h7; valid = 1'b1;
    tick();
    valid = 1'b0;
    check("post_rst_data", tx_data, 4'h7);
    check("post_rst_req", tx_req, 1);
    ack_async = 1'b1;
    done_seen = 1'b0;
    guard = 0;
    while (!done_seen && guard < 10) begin
      tick();
      if (done) done_seen = 1'b1;
      guard++;
    end
    check("post_rst_done", done_seen, 1);
    check("post_rst_ready", ready, 1);
    check("post_rst_no_err", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
